trigger_seq_writer: RTL and testbench

//   Producer side of the trigger command FIFO. Expands one configured acquisition

---
 rtl/trigger_seq_writer.sv | 165 ++++++++++++++++
 tb/tb_trigger_seq_writer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_seq_writer.sv
// Producer side of the trigger command FIFO: expands one latched acquisition
// configuration into a stream of 32-bit trigger commands, with repeat loop and abort.
module trigger_seq_writer #(
    parameter int REPS_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [28:0]       cfg_lockout_i,
    input  logic [REPS_W-1:0] cfg_n_reps_i,
    input  logic [28:0]       cfg_trigs_per_rep_i,
    input  logic [28:0]       cfg_delay_i,
    input  logic              cfg_force_i,
    output logic              cmd_word_wr_en_o,
    output logic [31:0]       cmd_word_o,
    input  logic              cmd_buf_full_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [REPS_W-1:0] reps_remaining_o
);

    // state        | meaning
    // S_IDLE       | waiting for start, no writes
    // S_LOCKOUT    | emitting SET_LOCKOUT(lockout)
    // S_SYNC       | emitting SYNC_CH, first word of each repetition
    // S_TRIG       | emitting FORCE_TRIG or EXPECT_EXT_TRIG(trigs_per_rep)
    // S_DELAY      | emitting DELAY(delay), skipped when delay is 0
    // S_CANCEL     | emitting CANCEL after an abort
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOCKOUT = 3'd1;
    localparam logic [2:0] S_SYNC    = 3'd2;
    localparam logic [2:0] S_TRIG    = 3'd3;
    localparam logic [2:0] S_DELAY   = 3'd4;
    localparam logic [2:0] S_CANCEL  = 3'd5;

    localparam logic [2:0] T_CANCEL  = 3'd1;
    localparam logic [2:0] T_SYNC    = 3'd2;
    localparam logic [2:0] T_LOCKOUT = 3'd3;
    localparam logic [2:0] T_EXPECT  = 3'd4;
    localparam logic [2:0] T_DELAY   = 3'd5;
    localparam logic [2:0] T_FORCE   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [28:0]       lockout_q, lockout_d;
    logic [28:0]       trigs_q, trigs_d;
    logic [28:0]       delay_q, delay_d;
    logic              force_q, force_d;
    logic [REPS_W-1:0] reps_q, reps_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              emit;
    logic              wr_en;
    logic              last_rep;

    assign emit     = (state_q >= S_LOCKOUT) && (state_q <= S_CANCEL);
    assign wr_en    = emit && !cmd_buf_full_i;
    assign last_rep = (reps_q == REPS_W'(1));

    always_comb begin
        cmd_word_o = 32'd0;
        case (state_q)
            S_LOCKOUT: cmd_word_o = {T_LOCKOUT, lockout_q};
            S_SYNC:    cmd_word_o = {T_SYNC, 29'd0};
            S_TRIG:    cmd_word_o = force_q ? {T_FORCE, 29'd0} : {T_EXPECT, trigs_q};
            S_DELAY:   cmd_word_o = {T_DELAY, delay_q};
            S_CANCEL:  cmd_word_o = {T_CANCEL, 29'd0};
            default:   cmd_word_o = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lockout_d = lockout_q;
        trigs_d   = trigs_q;
        delay_d   = delay_q;
        force_d   = force_q;
        reps_d    = reps_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    lockout_d = cfg_lockout_i;
                    trigs_d   = cfg_trigs_per_rep_i;
                    delay_d   = cfg_delay_i;
                    force_d   = cfg_force_i;
                    reps_d    = cfg_n_reps_i;
                    state_d   = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (wr_en) begin
                    if (reps_q != '0) begin
                        state_d = S_SYNC;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SYNC: begin
                if (wr_en) state_d = S_TRIG;
            end
            S_TRIG, S_DELAY: begin
                if (wr_en) begin
                    if (state_q == S_TRIG && delay_q != '0) begin
                        state_d = S_DELAY;
                    end else begin
                        reps_d = reps_q - REPS_W'(1);
                        if (last_rep) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_SYNC;
                        end
                    end
                end
            end
            S_CANCEL: begin
                if (wr_en) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    reps_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides sequencing; a word written on this same edge still stands.
        if (abort_i && emit && state_q != S_CANCEL) begin
            state_d = S_CANCEL;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            lockout_q <= '0;
            trigs_q   <= '0;
            delay_q   <= '0;
            force_q   <= 1'b0;
            reps_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lockout_q <= lockout_d;
            trigs_q   <= trigs_d;
            delay_q   <= delay_d;
            force_q   <= force_d;
            reps_q    <= reps_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_word_wr_en_o = wr_en;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign reps_remaining_o = reps_q;

endmodule

// File: tb/tb_trigger_seq_writer.sv
// Bench for trigger_seq_writer: table vectors, randomized runs against a word-list
// reference model, and directed stall / abort / reset sequences.
module tb_trigger_seq_writer;

    localparam int REPS_W = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start_i, abort_i;
    logic [28:0]       cfg_lockout_i, cfg_trigs_per_rep_i, cfg_delay_i;
    logic [REPS_W-1:0] cfg_n_reps_i;
    logic              cfg_force_i;
    logic              cmd_word_wr_en_o;
    logic [31:0]       cmd_word_o;
    logic              cmd_buf_full_i;
    logic              busy_o, done_o, aborted_o;
    logic [REPS_W-1:0] reps_remaining_o;

    always #5 clk = ~clk;

    trigger_seq_writer #(.REPS_W(REPS_W)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .cfg_lockout_i       (cfg_lockout_i),
        .cfg_n_reps_i        (cfg_n_reps_i),
        .cfg_trigs_per_rep_i (cfg_trigs_per_rep_i),
        .cfg_delay_i         (cfg_delay_i),
        .cfg_force_i         (cfg_force_i),
        .cmd_word_wr_en_o    (cmd_word_wr_en_o),
        .cmd_word_o          (cmd_word_o),
        .cmd_buf_full_i      (cmd_buf_full_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .aborted_o           (aborted_o),
        .reps_remaining_o    (reps_remaining_o)
    );

    typedef struct {
        logic [28:0]       lo;
        logic [REPS_W-1:0] nr;
        logic [28:0]       tr;
        logic [28:0]       dl;
        logic              fo;
        int                n_words;
        logic [31:0]       last;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[5];
    logic [31:0] exp7[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic ab, input logic full);
        @(negedge clk);
        start_i        = st;
        abort_i        = ab;
        cmd_buf_full_i = full;
        #1;
    endtask

    task automatic set_cfg(input logic [28:0] lo, input logic [REPS_W-1:0] nr,
                           input logic [28:0] tr, input logic [28:0] dl, input logic fo);
        cfg_lockout_i       = lo;
        cfg_n_reps_i        = nr;
        cfg_trigs_per_rep_i = tr;
        cfg_delay_i         = dl;
        cfg_force_i         = fo;
    endtask

    task automatic scramble_cfg();
        set_cfg(29'($urandom), REPS_W'($urandom), 29'($urandom), 29'($urandom), 1'($urandom));
    endtask

    // Reference: the full list of words a sequence must produce, built straight from the rules.
    task automatic build_model(input logic [28:0] lo, input logic [REPS_W-1:0] nr,
                               input logic [28:0] tr, input logic [28:0] dl, input logic fo);
        exp_q.delete();
        exp_q.push_back({3'd3, lo});
        for (int r = 0; r < int'(nr); r++) begin
            exp_q.push_back({3'd2, 29'd0});
            exp_q.push_back(fo ? {3'd6, 29'd0} : {3'd4, tr});
            if (dl != 0) exp_q.push_back({3'd5, dl});
        end
    endtask

    task automatic run_seq(input logic [28:0] lo, input logic [REPS_W-1:0] nr,
                           input logic [28:0] tr, input logic [28:0] dl, input logic fo,
                           input int full_pct, output int nwr, output logic [31:0] lastw);
        int cyc_since;
        bit got_done;
        int wpr;
        logic full, stx;
        nwr = 0;
        lastw = 32'd0;
        cyc_since = -1;
        got_done = 0;
        wpr = (dl != 0) ? 3 : 2;
        build_model(lo, nr, tr, dl, fo);
        set_cfg(lo, nr, tr, dl, fo);
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3000 && !got_done; c++) begin
            full = (int'($urandom_range(99)) < full_pct);
            stx  = (exp_q.size() > 0) && ($urandom_range(7) == 0);
            step(stx, 1'b0, full);
            if (c == 0) scramble_cfg();
            if (cyc_since >= 0) cyc_since++;
            if (done_o) begin
                got_done = 1;
                check("done_latency", cyc_since, 1);
            end
            if (full) check("wr_en_while_full", {31'd0, cmd_word_wr_en_o}, 32'd0);
            if (cmd_word_wr_en_o) begin
                check("reps_remaining", {16'd0, reps_remaining_o},
                      32'(int'(nr) - ((nwr > 0) ? (nwr - 1) / wpr : 0)));
                if (exp_q.size() == 0) begin
                    check("extra_word", cmd_word_o, 32'hFFFF_FFFF);
                end else begin
                    check("seq_word", cmd_word_o, exp_q.pop_front());
                end
                nwr++;
                lastw = cmd_word_o;
                cyc_since = 0;
            end
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("words_left", exp_q.size(), 0);
        check("busy_after_done", {31'd0, busy_o}, 32'd0);
        check("aborted_on_done", {31'd0, aborted_o}, 32'd0);
        check("reps_after_done", {16'd0, reps_remaining_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("done_one_cycle", {31'd0, done_o}, 32'd0);
    endtask

    task automatic run_abort(input logic [REPS_W-1:0] nr, input int abort_cyc, input int full_pct);
        int cyc_since;
        bit got_ab;
        logic full;
        logic [28:0] lo, tr, dl;
        lo = 29'($urandom);
        tr = 29'($urandom);
        dl = 29'($urandom_range(3));
        cyc_since = -1;
        got_ab = 0;
        build_model(lo, nr, tr, dl, 1'b0);
        set_cfg(lo, nr, tr, dl, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 500 && !got_ab; c++) begin
            full = (int'($urandom_range(99)) < full_pct);
            step(1'b0, c == abort_cyc, full);
            if (cyc_since >= 0) cyc_since++;
            if (aborted_o) begin
                got_ab = 1;
                check("aborted_latency", cyc_since, 1);
                check("done_with_abort", {31'd0, done_o}, 32'd0);
            end
            if (cmd_word_wr_en_o) begin
                if (c <= abort_cyc) begin
                    check("pre_abort_word", cmd_word_o, exp_q.pop_front());
                end else begin
                    check("cancel_word", cmd_word_o, 32'h2000_0000);
                    check("single_cancel", cyc_since, -1);
                    cyc_since = 0;
                end
            end
        end
        check("aborted_seen", {31'd0, got_ab}, 32'd1);
        check("busy_after_abort", {31'd0, busy_o}, 32'd0);
        check("reps_after_abort", {16'd0, reps_remaining_o}, 32'd0);
    endtask

    initial begin
        int          nwr;
        logic [31:0] lastw;

        vecs[0] = '{lo: 29'd100, nr: 16'd2, tr: 29'd3, dl: 29'd50, fo: 1'b0, n_words: 7, last: 32'hA000_0032};
        vecs[1] = '{lo: 29'd7,   nr: 16'd0, tr: 29'd5, dl: 29'd9,  fo: 1'b0, n_words: 1, last: 32'h6000_0007};
        vecs[2] = '{lo: 29'd1,   nr: 16'd1, tr: 29'd4, dl: 29'd0,  fo: 1'b1, n_words: 3, last: 32'hC000_0000};
        vecs[3] = '{lo: 29'd0,   nr: 16'd3, tr: 29'd0, dl: 29'd0,  fo: 1'b0, n_words: 7, last: 32'h8000_0000};
        vecs[4] = '{lo: 29'h1FFF_FFFF, nr: 16'd1, tr: 29'h1FFF_FFFF, dl: 29'h1FFF_FFFF, fo: 1'b0,
                    n_words: 4, last: 32'hBFFF_FFFF};
        exp7 = '{32'h6000_0064, 32'h4000_0000, 32'h8000_0003, 32'hA000_0032,
                 32'h4000_0000, 32'h8000_0003, 32'hA000_0032};

        resetn = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        cmd_buf_full_i = 1'b0;
        set_cfg(29'd0, 16'd0, 29'd0, 29'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_aborted", {31'd0, aborted_o}, 32'd0);
        check("rst_reps", {16'd0, reps_remaining_o}, 32'd0);
        check("rst_wr_en", {31'd0, cmd_word_wr_en_o}, 32'd0);

        // Basic sequence with a 10-cycle stall in EMIT_SYNC and start pulses while busy.
        set_cfg(29'd100, 16'd2, 29'd3, 29'd50, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("basic_wr0", {31'd0, cmd_word_wr_en_o}, 32'd1);
        check("basic_w0", cmd_word_o, exp7[0]);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check("stall_wr_en", {31'd0, cmd_word_wr_en_o}, 32'd0);
            check("stall_word", cmd_word_o, 32'h4000_0000);
        end
        for (int i = 1; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("basic_wr", {31'd0, cmd_word_wr_en_o}, 32'd1);
            check("basic_w", cmd_word_o, exp7[i]);
        end
        step(1'b0, 1'b0, 1'b0);
        check("basic_done", {31'd0, done_o}, 32'd1);
        check("basic_busy", {31'd0, busy_o}, 32'd0);
        check("basic_no_wr", {31'd0, cmd_word_wr_en_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("basic_done_drop", {31'd0, done_o}, 32'd0);

        // Abort while EMIT_TRIG is stalled on a full FIFO.
        set_cfg(29'd5, 16'd3, 29'd2, 29'd8, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("ab_trig_wr", {31'd0, cmd_word_wr_en_o}, 32'd0);
        check("ab_trig_word", cmd_word_o, 32'h8000_0002);
        step(1'b0, 1'b0, 1'b0);
        check("ab_cancel_wr", {31'd0, cmd_word_wr_en_o}, 32'd1);
        check("ab_cancel_word", cmd_word_o, 32'h2000_0000);
        step(1'b0, 1'b0, 1'b0);
        check("ab_aborted", {31'd0, aborted_o}, 32'd1);
        check("ab_done", {31'd0, done_o}, 32'd0);
        check("ab_busy", {31'd0, busy_o}, 32'd0);
        check("ab_reps", {16'd0, reps_remaining_o}, 32'd0);
        check("ab_no_delay", {31'd0, cmd_word_wr_en_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("ab_aborted_drop", {31'd0, aborted_o}, 32'd0);

        // Abort in IDLE, and start together with abort, must both be ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("idle_abort_wr", {31'd0, cmd_word_wr_en_o}, 32'd0);
            check("idle_abort_ab", {31'd0, aborted_o}, 32'd0);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("start_abort_busy", {31'd0, busy_o}, 32'd0);

        // Reset mid-repetition.
        set_cfg(29'd9, 16'd4, 29'd1, 29'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_done", {31'd0, done_o}, 32'd0);
        check("mid_rst_aborted", {31'd0, aborted_o}, 32'd0);
        check("mid_rst_reps", {16'd0, reps_remaining_o}, 32'd0);
        check("mid_rst_wr", {31'd0, cmd_word_wr_en_o}, 32'd0);
        check("mid_rst_word", cmd_word_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("no_cancel_after_rst", {31'd0, cmd_word_wr_en_o}, 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            run_seq(vecs[i].lo, vecs[i].nr, vecs[i].tr, vecs[i].dl, vecs[i].fo,
                    (i == 0) ? 0 : 30, nwr, lastw);
            check("vec_n_words", nwr, vecs[i].n_words);
            check("vec_last_word", lastw, vecs[i].last);
        end

        for (int i = 0; i < 20; i++) begin
            run_seq(29'($urandom), REPS_W'($urandom_range(6)), 29'($urandom),
                    ($urandom_range(1) == 0) ? 29'd0 : 29'($urandom), 1'($urandom),
                    int'($urandom_range(60)), nwr, lastw);
        end

        for (int i = 0; i < 10; i++) begin
            run_abort(REPS_W'($urandom_range(2, 5)), int'($urandom_range(1, 4)),
                      int'($urandom_range(50)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
